// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 16-bit memory bus: data port has priority,
// and a streak counter caps consecutive data grants while a fetch is waiting.
module mem_bus_arbiter #(
  parameter int DATA_BURST_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_t;

  localparam logic [3:0] LIMIT = 4'(DATA_BURST_LIMIT);

  state_t     state;
  logic [3:0] streak;
  logic       instr_turn;

  // A waiting fetch wins a tie only once the data streak has hit the limit.
  assign instr_turn = instr_m_access && (streak == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_m_access && !instr_turn) begin
            state <= GRANT_D;
            if (!instr_m_access)
              streak <= '0;
            else if (streak != LIMIT)
              streak <= streak + 4'd1;
          end else if (instr_m_access) begin
            state  <= GRANT_I;
            streak <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (q_m_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus fields follow the granted port; IDLE drives everything to zero.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state)
      GRANT_I: begin
        q_m_access  = 1'b1;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      GRANT_D: begin
        q_m_access   = 1'b1;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level owner model.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:1] i_addr;
  logic        i_req;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic [19:1] d_addr;
  logic [15:0] d_wdata;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_bs;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [19:1] q_addr;
  logic [15:0] q_wdata;
  logic [15:0] mem_rdata;
  logic        q_access;
  logic        mem_ack;
  logic        q_wr;
  logic [1:0]  q_bs;

  mem_bus_arbiter #(.DATA_BURST_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .reset           (rst),
    .instr_m_addr    (i_addr),
    .instr_m_access  (i_req),
    .instr_m_ack     (i_ack),
    .instr_m_data_in (i_rdata),
    .data_m_addr     (d_addr),
    .data_m_data_out (d_wdata),
    .data_m_access   (d_req),
    .data_m_wr_en    (d_wr),
    .data_m_bytesel  (d_bs),
    .data_m_ack      (d_ack),
    .data_m_data_in  (d_rdata),
    .q_m_addr        (q_addr),
    .q_m_data_out    (q_wdata),
    .q_m_data_in     (mem_rdata),
    .q_m_access      (q_access),
    .q_m_ack         (mem_ack),
    .q_m_wr_en       (q_wr),
    .q_m_bytesel     (q_bs)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passed = 0;
  // Model: who currently owns the bus (0 none, 1 fetch, 2 data) and how many
  // data grants have gone by while a fetch was kept waiting.
  int    m_owner = 0;
  int    m_waited = 0;
  int    mem_cnt = 0;
  int    mem_lat = 0;
  bit    i_again = 0;
  bit    d_again = 0;
  bit    e_iack;
  bit    e_dack;
  string grant_log = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chkStr(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) passed++;
    else $error("[TB] FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [19:1] e_addr;
    logic [15:0] e_wdata;
    logic        e_wr;
    logic [1:0]  e_bs;
    @(negedge clk);
    e_addr  = (m_owner == 1) ? i_addr : (m_owner == 2) ? d_addr : '0;
    e_wdata = (m_owner == 2) ? d_wdata : '0;
    e_wr    = (m_owner == 2) ? d_wr : 1'b0;
    e_bs    = (m_owner == 1) ? 2'b11 : (m_owner == 2) ? d_bs : 2'b00;
    e_iack  = (m_owner == 1) && mem_ack;
    e_dack  = (m_owner == 2) && mem_ack;
    chk({tag, "_access"}, 32'(q_access), 32'(m_owner != 0));
    chk({tag, "_addr"}, 32'(q_addr), 32'(e_addr));
    chk({tag, "_wdata"}, 32'(q_wdata), 32'(e_wdata));
    chk({tag, "_wr"}, 32'(q_wr), 32'(e_wr));
    chk({tag, "_bs"}, 32'(q_bs), 32'(e_bs));
    chk({tag, "_iack"}, 32'(i_ack), 32'(e_iack));
    chk({tag, "_dack"}, 32'(d_ack), 32'(e_dack));
    chk({tag, "_irdata"}, 32'(i_rdata), 32'(mem_rdata));
    chk({tag, "_drdata"}, 32'(d_rdata), 32'(mem_rdata));
    if (i_ack) grant_log = {grant_log, "I"};
    if (d_ack) grant_log = {grant_log, "D"};
  endtask

  // Next bus owner from the arbitration rules, evaluated at the coming edge.
  task automatic advanceModel();
    int prev;
    prev = m_owner;
    if (rst) begin
      m_owner  = 0;
      m_waited = 0;
    end else if (m_owner == 0) begin
      if (d_req && !(i_req && m_waited >= LIMIT)) begin
        m_owner  = 2;
        m_waited = i_req ? ((m_waited + 1 > LIMIT) ? LIMIT : m_waited + 1) : 0;
      end else if (i_req) begin
        m_owner  = 1;
        m_waited = 0;
      end
    end else if (mem_ack) begin
      m_owner = 0;
    end
    mem_cnt = (m_owner != 0 && prev != 0) ? mem_cnt + 1 : 0;
  endtask

  // One bus cycle: memory responds, outputs are checked, requesters react to acks.
  task automatic applyStimulus(input string tag, input bit spurious);
    mem_ack   = ((m_owner != 0) && (mem_cnt >= mem_lat)) || spurious;
    mem_rdata = 16'($urandom);
    checkOutput(tag);
    advanceModel();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (e_iack) begin
      i_req = i_again;
      if (i_again) i_addr = 19'($urandom);
    end
    if (e_dack) begin
      d_req = d_again;
      if (d_again) begin
        d_addr  = 19'($urandom);
        d_wdata = 16'($urandom);
        d_wr    = 1'($urandom);
        d_bs    = 2'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wr = 1'b0; d_bs = 2'b00;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) applyStimulus("reset", 1'b0);
    rst = 1'b0;

    // Lone instruction read, memory answers two cycles into the access.
    i_req = 1'b1; i_addr = 19'h12345; mem_lat = 2; grant_log = "";
    for (int k = 0; k < 5; k++) applyStimulus("ifetch", 1'b0);
    chkStr("ifetch_order", grant_log, "I");

    // Lone data write with a single byte lane enabled.
    d_req = 1'b1; d_addr = 19'h00010; d_wdata = 16'hA55A; d_wr = 1'b1; d_bs = 2'b01;
    mem_lat = 0; grant_log = "";
    for (int k = 0; k < 3; k++) applyStimulus("dwrite", 1'b0);
    chkStr("dwrite_order", grant_log, "D");

    // Simultaneous requests: data first, then the fetch after one idle cycle.
    i_req = 1'b1; i_addr = 19'h00abc; d_req = 1'b1; d_addr = 19'h7ff00; d_wr = 1'b0;
    d_bs = 2'b11; mem_lat = 1; grant_log = "";
    for (int k = 0; k < 8; k++) applyStimulus("both", 1'b0);
    chkStr("both_order", grant_log, "DI");

    // Data hammers the bus while a fetch waits: the fetch gets in after LIMIT grants.
    i_req = 1'b1; i_addr = 19'h01111; d_req = 1'b1; d_again = 1; mem_lat = 0; grant_log = "";
    for (int k = 0; k < 11; k++) applyStimulus("starve", 1'b0);
    d_again = 0;
    for (int k = 0; k < 3; k++) applyStimulus("starve", 1'b0);
    chkStr("starve_order", grant_log, "DDDDID");

    // Reset in the middle of a data grant abandons it; a late ack goes nowhere.
    d_req = 1'b1; d_addr = 19'h2aaaa; d_wr = 1'b1; d_wdata = 16'h1234; mem_lat = 3;
    grant_log = "";
    for (int k = 0; k < 2; k++) applyStimulus("rstgrant", 1'b0);
    rst = 1'b1; d_req = 1'b0;
    applyStimulus("rstgrant", 1'b0);
    rst = 1'b0;
    applyStimulus("rstgrant_idle", 1'b0);
    applyStimulus("late_ack", 1'b1);
    applyStimulus("spurious", 1'b1);
    applyStimulus("spurious_after", 1'b0);
    chkStr("rstgrant_order", grant_log, "");

    // Randomized traffic, latencies, spurious acks and occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(63) == 0);
      if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = 19'($urandom);
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_addr = 19'($urandom); d_wdata = 16'($urandom);
        d_wr = 1'($urandom); d_bs = 2'($urandom);
      end
      i_again = 1'($urandom);
      d_again = 1'($urandom);
      if (m_owner == 0) mem_lat = $urandom_range(3);
      applyStimulus("random", (m_owner == 0) && ($urandom_range(7) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
